// File: rtl/piso_if.sv
// Load handshake, shift enable and serial-side status of the PISO serializer.
// master = word producer / bit-rate source, slave = serializer.
interface piso_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] load_data;
  logic             load_valid;
  logic             load_ready;
  logic             shift_en;
  logic             q;
  logic             q_valid;
  logic             busy;
  logic             frame_done;

  modport master (
    output load_data,
    output load_valid,
    output shift_en,
    input  load_ready,
    input  q,
    input  q_valid,
    input  busy,
    input  frame_done
  );

  modport slave (
    input  load_data,
    input  load_valid,
    input  shift_en,
    output load_ready,
    output q,
    output q_valid,
    output busy,
    output frame_done
  );
endinterface

// File: rtl/piso_serializer.sv
// Parallel-in/serial-out shifter: WIDTH-bit words in over valid/ready, one bit per
// shift_en on a registered q, optional trailing parity bit, gap-free back-to-back frames.
module piso_serializer #(
  parameter int WIDTH      = 8,
  parameter int LSB_FIRST  = 0,
  parameter int PARITY_EN  = 0,
  parameter int ODD_PARITY = 0,
  parameter int IDLE_LEVEL = 1
) (
  input  logic    clk,
  input  logic    rst_n,
  piso_if.slave   bus
);

  localparam int             CW       = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0]  CNT_LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0]  CNT_ONE  = CW'(1);
  localparam logic [CW-1:0]  CNT_ZERO = CW'(0);
  localparam logic           IDLE_BIT = (IDLE_LEVEL != 0);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_PARITY = 2'd2
  } state_t;

  state_t           state_q,   state_d;
  logic [CW-1:0]    cnt_q,     cnt_d;
  logic [WIDTH-1:0] shreg_q,   shreg_d;
  logic             par_q,     par_d;
  logic             q_q,       q_d;
  logic             q_valid_q, q_valid_d;
  logic             done_q,    done_d;
  logic             ready_s;
  logic             accept_s;

  function automatic logic parity_of(input logic [WIDTH-1:0] w);
    return (ODD_PARITY != 0) ? ~(^w) : (^w);
  endfunction

  function automatic logic first_bit(input logic [WIDTH-1:0] w);
    return (LSB_FIRST != 0) ? w[0] : w[WIDTH-1];
  endfunction

  // Drop the bit just consumed so the next one sits in the "first" position.
  function automatic logic [WIDTH-1:0] advance(input logic [WIDTH-1:0] w);
    return (LSB_FIRST != 0) ? {1'b0, w[WIDTH-1:1]} : {w[WIDTH-2:0], 1'b0};
  endfunction

  // Load acceptance: idle, or the edge that consumes the final bit of a frame.
  always_comb begin
    ready_s = 1'b0;
    case (state_q)
      ST_IDLE:   ready_s = 1'b1;
      ST_SHIFT:  ready_s = (cnt_q == CNT_LAST) && bus.shift_en && (PARITY_EN == 0);
      ST_PARITY: ready_s = bus.shift_en;
      default:   ready_s = 1'b0;
    endcase
  end

  assign accept_s = bus.load_valid & ready_s;

  // Next-state and output-register computation; an accepted word overrides the end-of-frame path.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    shreg_d   = shreg_q;
    par_d     = par_q;
    q_d       = q_q;
    q_valid_d = q_valid_q;
    done_d    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        state_d = ST_IDLE;
      end
      ST_SHIFT: begin
        if (bus.shift_en) begin
          if (cnt_q == CNT_LAST) begin
            if (PARITY_EN != 0) begin
              state_d = ST_PARITY;
              q_d     = par_q;
            end else begin
              done_d    = 1'b1;
              state_d   = ST_IDLE;
              cnt_d     = CNT_ZERO;
              q_d       = IDLE_BIT;
              q_valid_d = 1'b0;
            end
          end else begin
            cnt_d   = cnt_q + CNT_ONE;
            shreg_d = advance(shreg_q);
            q_d     = first_bit(advance(shreg_q));
          end
        end else begin
          state_d = ST_SHIFT;
        end
      end
      ST_PARITY: begin
        if (bus.shift_en) begin
          done_d    = 1'b1;
          state_d   = ST_IDLE;
          cnt_d     = CNT_ZERO;
          q_d       = IDLE_BIT;
          q_valid_d = 1'b0;
        end else begin
          state_d = ST_PARITY;
        end
      end
      default: begin
        state_d   = ST_IDLE;
        cnt_d     = CNT_ZERO;
        q_d       = IDLE_BIT;
        q_valid_d = 1'b0;
      end
    endcase

    if (accept_s) begin
      state_d   = ST_SHIFT;
      cnt_d     = CNT_ZERO;
      shreg_d   = bus.load_data;
      par_d     = parity_of(bus.load_data);
      q_d       = first_bit(bus.load_data);
      q_valid_d = 1'b1;
    end else begin
      par_d = par_d;
    end
  end

  // State, datapath and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= CNT_ZERO;
      shreg_q   <= '0;
      par_q     <= 1'b0;
      q_q       <= IDLE_BIT;
      q_valid_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      shreg_q   <= shreg_d;
      par_q     <= par_d;
      q_q       <= q_d;
      q_valid_q <= q_valid_d;
      done_q    <= done_d;
    end
  end

  assign bus.load_ready = ready_s;
  assign bus.q          = q_q;
  assign bus.q_valid    = q_valid_q;
  assign bus.busy       = (state_q != ST_IDLE);
  assign bus.frame_done = done_q;

endmodule

// File: tb/tb_piso_serializer.sv
// Five serializer configurations share one stimulus stream; each is compared every
// cycle against a queue-of-pending-bits reference model, plus directed bit-order checks.
module tb_piso_serializer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] din;
  logic       lv;
  logic       se;

  always #5 clk = ~clk;

  logic o_q[5], o_qv[5], o_busy[5], o_done[5], o_rdy[5];

  // dut0 W4 MSB | dut1 W4 LSB | dut2 W4 MSB even parity | dut3 W4 MSB odd parity | dut4 W8 LSB idle-low
  for (genvar g = 0; g < 5; g++) begin : g_dut
    localparam int W   = (g == 4) ? 8 : 4;
    localparam int LSB = (g == 1 || g == 4) ? 1 : 0;
    localparam int PAR = (g == 2 || g == 3) ? 1 : 0;
    localparam int ODD = (g == 3) ? 1 : 0;
    localparam int IDL = (g == 4) ? 0 : 1;

    piso_if #(.WIDTH(W)) bus ();

    piso_serializer #(
      .WIDTH(W), .LSB_FIRST(LSB), .PARITY_EN(PAR), .ODD_PARITY(ODD), .IDLE_LEVEL(IDL)
    ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
    );

    assign bus.load_data  = din[W-1:0];
    assign bus.load_valid = lv;
    assign bus.shift_en   = se;
    assign o_q[g]    = bus.q;
    assign o_qv[g]   = bus.q_valid;
    assign o_busy[g] = bus.busy;
    assign o_done[g] = bus.frame_done;
    assign o_rdy[g]  = bus.load_ready;
  end

  int tests = 0;
  int fails = 0;

  int          mw[5];
  bit          mlsb[5], mpar[5], modd[5];
  logic        midle[5];
  logic [15:0] mbits[5];
  int          mlen[5];
  logic        mdone[5];
  logic [15:0] hist[5];
  int          dcnt[5];

  task automatic chk(input string tag, input int i, input logic [15:0] got, input logic [15:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s dut%0d: got %b expected %b", tag, i, got, exp);
    end
  endtask

  task automatic check_all();
    for (int i = 0; i < 5; i++) begin
      chk("q",          i, 16'(o_q[i]),    16'((mlen[i] > 0) ? mbits[i][0] : midle[i]));
      chk("q_valid",    i, 16'(o_qv[i]),   16'(mlen[i] > 0));
      chk("busy",       i, 16'(o_busy[i]), 16'(mlen[i] > 0));
      chk("frame_done", i, 16'(o_done[i]), 16'(mdone[i]));
      chk("load_ready", i, 16'(o_rdy[i]),  16'((mlen[i] == 0) || (se && mlen[i] == 1)));
      if (o_qv[i] && se) hist[i] = {hist[i][14:0], o_q[i]};
      if (o_done[i]) dcnt[i]++;
    end
  endtask

  task automatic model_load(input int i);
    logic [7:0] w;
    logic       p;
    w = (mw[i] == 8) ? din : {4'b0000, din[3:0]};
    p = ^w;
    mbits[i] = 16'h0000;
    for (int k = 0; k < mw[i]; k++) mbits[i][k] = mlsb[i] ? w[k] : w[mw[i] - 1 - k];
    mlen[i] = mw[i];
    if (mpar[i]) begin
      mbits[i][mw[i]] = modd[i] ? ~p : p;
      mlen[i]++;
    end
  endtask

  task automatic model_step();
    for (int i = 0; i < 5; i++) begin
      logic rdy;
      logic nd;
      rdy = (mlen[i] == 0) || (se && mlen[i] == 1);
      nd  = 1'b0;
      if (se && mlen[i] > 0) begin
        nd       = (mlen[i] == 1);
        mbits[i] = mbits[i] >> 1;
        mlen[i]--;
      end
      if (lv && rdy) model_load(i);
      mdone[i] = nd;
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 5; i++) begin
      mlen[i]  = 0;
      mbits[i] = 16'h0000;
      mdone[i] = 1'b0;
    end
  endtask

  task automatic clear_hist();
    for (int i = 0; i < 5; i++) begin
      hist[i] = 16'h0000;
      dcnt[i] = 0;
    end
  endtask

  task automatic cycle(input logic v, input logic s, input logic [7:0] d);
    lv  = v;
    se  = s;
    din = d;
    @(negedge clk);
    check_all();
    model_step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 5; i++) begin
      mw[i]    = (i == 4) ? 8 : 4;
      mlsb[i]  = (i == 1 || i == 4);
      mpar[i]  = (i == 2 || i == 3);
      modd[i]  = (i == 3);
      midle[i] = (i == 4) ? 1'b0 : 1'b1;
    end
    lv = 1'b0; se = 1'b0; din = 8'h00;
    model_reset();
    clear_hist();

    // Reset state
    #12;
    check_all();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cycle(1'b0, 1'b0, 8'h00);
    cycle(1'b0, 1'b1, 8'h00);

    // Single word, constant shift_en
    clear_hist();
    cycle(1'b1, 1'b1, 8'h0B);
    repeat (10) cycle(1'b0, 1'b1, 8'h00);
    chk("t1_bits", 0, hist[0], 16'b1011);
    chk("t1_bits", 1, hist[1], 16'b1101);
    chk("t1_bits", 2, hist[2], 16'b10111);
    chk("t1_bits", 3, hist[3], 16'b10110);
    chk("t1_bits", 4, hist[4], 16'b11010000);
    for (int i = 0; i < 5; i++) chk("t1_done_cnt", i, 16'(dcnt[i]), 16'd1);

    // Back-to-back: second word held valid until taken on the last-bit edge
    clear_hist();
    cycle(1'b1, 1'b1, 8'h0B);
    repeat (5) cycle(1'b1, 1'b1, 8'h00);
    repeat (10) cycle(1'b0, 1'b1, 8'h00);
    chk("t4_bits", 0, hist[0], 16'b10110000);
    chk("t4_bits", 1, hist[1], 16'b11010000);
    chk("t4_bits", 2, hist[2], 16'b1011100000);
    chk("t4_bits", 3, hist[3], 16'b1011000001);
    chk("t4_bits", 4, hist[4], 16'b11010000);
    for (int i = 0; i < 4; i++) chk("t4_done_cnt", i, 16'(dcnt[i]), 16'd2);
    chk("t4_done_cnt", 4, 16'(dcnt[4]), 16'd1);

    // shift_en active one cycle in three
    clear_hist();
    cycle(1'b1, 1'b0, 8'h06);
    for (int k = 0; k < 40; k++) cycle(1'b0, (k % 3) == 2, 8'h00);
    chk("t5_bits", 0, hist[0], 16'b0110);
    chk("t5_bits", 4, hist[4], 16'b01100000);
    for (int i = 0; i < 5; i++) chk("t5_done_cnt", i, 16'(dcnt[i]), 16'd1);

    // Asynchronous reset after two bits consumed
    clear_hist();
    cycle(1'b1, 1'b1, 8'h0B);
    cycle(1'b0, 1'b1, 8'h00);
    cycle(1'b0, 1'b1, 8'h00);
    #2;
    rst_n = 1'b0;
    #1;
    for (int i = 0; i < 5; i++) begin
      chk("rst_q",       i, 16'(o_q[i]),    16'(midle[i]));
      chk("rst_q_valid", i, 16'(o_qv[i]),   16'd0);
      chk("rst_busy",    i, 16'(o_busy[i]), 16'd0);
      chk("rst_done",    i, 16'(o_done[i]), 16'd0);
    end
    model_reset();
    cycle(1'b0, 1'b1, 8'h00);
    cycle(1'b0, 1'b1, 8'h00);
    rst_n = 1'b1;
    repeat (3) cycle(1'b0, 1'b0, 8'h00);
    for (int i = 0; i < 5; i++) chk("t6_no_done", i, 16'(dcnt[i]), 16'd0);

    // Randomised traffic
    repeat (400) cycle(1'($urandom_range(0, 1)), ($urandom_range(0, 3) != 0), 8'($urandom));
    repeat (30) cycle(1'b0, 1'b1, 8'h00);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
